p2p_cfg_regs: RTL
=================

P2P_CFG_REGS -- requirements
Module: p2p_cfg_regs

Interface
REQ-001 SHALL have parameter DATA_W, default 256, beat width of the cfg stream (multiple of 64).
REQ-002 SHALL have parameter HEAD_W, default 128, P2P request head width.
REQ-003 SHALL have parameter REG_NUM, default 8, count of 64-bit registers (power of 2, 2..64).
REQ-004 SHALL have one clock and an asynchronous active-low reset, named as follows:
- clk  in  1  sole clock
- rst_n  in  1  asynchronous, active-low reset
REQ-005 SHALL have the following request, response and register ports:
- p2p_cfg_req_valid  in  1  request beat valid
- p2p_cfg_req_last  in  1  last beat of request
- p2p_cfg_req_data  in  DATA_W  write payload, word k = bits [64k+63:64k]
- p2p_cfg_req_head  in  HEAD_W  [127]=is_wr, [63:32]=byte addr, [12:0]=byte_len; other bits ignored
- p2p_cfg_req_ready  out  1  request beat accepted
- p2p_cfg_rrsp_valid  out  1  read response valid
- p2p_cfg_rrsp_last  out  1  always equal to rrsp_valid
- p2p_cfg_rrsp_data  out  DATA_W  [63:0]=read word, upper bits 0
- p2p_cfg_rrsp_ready  in  1  response accepted
- cfg_regs  out  64*REG_NUM  flattened register file, reg i = bits [64i+63:64i]

Function
REQ-006 SHALL implement a one-hot FSM with states IDLE, WR, RD_REQ and RD_RSP.
REQ-007 IDLE SHALL hold req_ready=0; on req_valid it SHALL latch the head and go to WR if is_wr=1, else to RD_REQ.
REQ-008 Start index SHALL be S=addr[log2(REG_NUM)+2:3]; addr[2:0] and higher addr bits SHALL be ignored.
REQ-009 Word count SHALL be W=ceil(byte_len/8), computed in 11 bits; byte_len=0 SHALL give W=0, so the request writes nothing but its beats are still consumed.
REQ-010 In WR, req_ready SHALL be 1; each accepted beat b (0-based) SHALL carry words n=b*(DATA_W/64)+k.
REQ-011 For each such word, reg[S+n] SHALL be written when n<W and S+n<REG_NUM; out-of-range words SHALL be dropped with no wrap.
REQ-012 Register update SHALL be visible on cfg_regs one cycle after the beat handshake.
REQ-013 In WR, a handshake with last=1 SHALL return the FSM to IDLE; beats beyond W words SHALL be consumed silently.
REQ-014 Reads SHALL support exactly one 64-bit word, regardless of byte_len.
REQ-015 In RD_REQ, req_ready SHALL be 1; the accepted beat's data SHALL be discarded.
REQ-016 In RD_REQ, a handshake with last=1 SHALL capture reg[S], or 0 if S>=REG_NUM, into the response register and go to RD_RSP; a non-last beat SHALL remain in RD_REQ.
REQ-017 In RD_RSP, rrsp_valid SHALL be 1 with data held stable until rrsp_ready; on handshake the FSM SHALL go to IDLE.
REQ-018 rrsp_valid SHALL be 0 outside RD_RSP; rrsp_data SHALL be 0 whenever rrsp_valid=0.
REQ-019 req_ready SHALL be 0 in IDLE and RD_RSP; there SHALL be at most one outstanding read.
REQ-020 Minimum read latency SHALL be: head seen at cycle 0, beat accepted at cycle 1, rrsp_valid at cycle 2.
REQ-021 Minimum write throughput SHALL be one beat per cycle after a one-cycle IDLE bubble per request.
REQ-022 A read captured in RD_REQ SHALL see all writes from earlier requests; writes and reads never overlap.
REQ-023 A held request head SHALL be latched only in IDLE; head changes mid-request SHALL be ignored.

Reset
REQ-024 On rst_n=0 the FSM SHALL enter IDLE immediately.
REQ-025 On reset, all registers, the beat counter, latched head and response data SHALL be 0.
REQ-026 During and after reset, req_ready, rrsp_valid and rrsp_last SHALL be 0 and rrsp_data SHALL be 0.
REQ-027 Reset mid-request SHALL abandon the request; partial register writes already committed SHALL be cleared to 0.

Verification
REQ-028 Single write: is_wr=1, addr=0x10, byte_len=8, one beat with data[63:0]=0xDEAD_BEEF_0000_0001 -> reg[2]=that value one cycle after the handshake; other registers remain 0.
REQ-029 Multi-beat write: addr=0x0, byte_len=64, two beats with words 1..8 -> reg[0..7]=1..8; a third trailing beat with last=1 is consumed with no register change.
REQ-030 Read after write: write reg[5]=0xA5A5, then read addr=0x28 -> rrsp_data[63:0]=0xA5A5, rrsp_last=1, upper bits 0, rrsp_valid at cycle 2 after head presentation.
REQ-031 Response backpressure: hold rrsp_ready=0 for 5 cycles -> rrsp_valid and data stay stable, req_ready=0 throughout; a new request is accepted only after the response handshake.
REQ-032 Boundary: write addr=0x38, byte_len=24 -> only reg[7] is written, the overflow words are dropped; read addr=0x40 with REG_NUM=8 -> returns 0 (index wraps to 0 only because addr bit 6 is ignored; the bench checks reg[0]).
REQ-033 Reset mid-WR after one of two beats -> all registers 0, FSM in IDLE, req_ready=0; a following write completes normally.

Source files
------------

// File: rtl/p2p_cfg_regs_if.sv
`default_nettype none
// ============================================================================
// Module      : p2p_cfg_regs_if
// Description : Request/response stream bundle for the P2P config register
//               block. The master drives requests and accepts responses; the
//               slave (register block) does the opposite.
// Revision    : 1.0 - initial release
// ============================================================================
interface p2p_cfg_regs_if #(
    parameter int DATA_W = 256,
    parameter int HEAD_W = 128
);
    logic              p2p_cfg_req_valid;
    logic              p2p_cfg_req_last;
    logic [DATA_W-1:0] p2p_cfg_req_data;
    logic [HEAD_W-1:0] p2p_cfg_req_head;
    logic              p2p_cfg_req_ready;
    logic              p2p_cfg_rrsp_valid;
    logic              p2p_cfg_rrsp_last;
    logic [DATA_W-1:0] p2p_cfg_rrsp_data;
    logic              p2p_cfg_rrsp_ready;

    modport master (
        output p2p_cfg_req_valid,
        output p2p_cfg_req_last,
        output p2p_cfg_req_data,
        output p2p_cfg_req_head,
        input  p2p_cfg_req_ready,
        input  p2p_cfg_rrsp_valid,
        input  p2p_cfg_rrsp_last,
        input  p2p_cfg_rrsp_data,
        output p2p_cfg_rrsp_ready
    );

    modport slave (
        input  p2p_cfg_req_valid,
        input  p2p_cfg_req_last,
        input  p2p_cfg_req_data,
        input  p2p_cfg_req_head,
        output p2p_cfg_req_ready,
        output p2p_cfg_rrsp_valid,
        output p2p_cfg_rrsp_last,
        output p2p_cfg_rrsp_data,
        input  p2p_cfg_rrsp_ready
    );
endinterface
`default_nettype wire

// File: rtl/p2p_cfg_regs.sv
`default_nettype none
// ============================================================================
// Module      : p2p_cfg_regs
// Description : Bank of REG_NUM 64-bit configuration registers written and
//               read through a P2P request stream. Writes span any number of
//               beats; reads return a single 64-bit word.
// Revision    : 1.0 - initial release
// ============================================================================
module p2p_cfg_regs #(
    parameter int DATA_W  = 256,
    parameter int HEAD_W  = 128,
    parameter int REG_NUM = 8
) (
    input  wire                       clk,
    input  wire                       rst_n,
    p2p_cfg_regs_if.slave             bus,
    output logic [64*REG_NUM-1:0]     cfg_regs
);

    // Words per beat and register index width
    localparam int c_WPB      = DATA_W / 64;
    localparam int c_IDX_W    = $clog2(REG_NUM);
    // Byte address sits at head[63:32]; word index starts at address bit 3
    localparam int c_ADDR_LSB = 32 + 3;
    localparam int c_IS_WR    = 127;

    // One-hot encoded states
    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_WR     = 4'b0010,
        ST_RD_REQ = 4'b0100,
        ST_RD_RSP = 4'b1000
    } state_t;

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_start;
    logic [10:0]          r_wcnt;
    logic [10:0]          r_beat;
    logic [63:0]          r_regs [REG_NUM];
    logic [63:0]          r_rdata;

    logic [c_IDX_W-1:0]   w_head_start;
    logic [13:0]          w_len_rnd;
    logic                 w_head_is_wr;
    logic                 w_req_ready;
    logic                 w_wr_hs;
    logic [REG_NUM-1:0]   w_we;
    logic [63:0]          w_wdata [REG_NUM];
    logic                 w_unused_ok;

    // Head decode; only is_wr, the word-aligned index bits and byte_len matter
    assign w_head_start = bus.p2p_cfg_req_head[c_ADDR_LSB +: c_IDX_W];
    assign w_len_rnd    = {1'b0, bus.p2p_cfg_req_head[12:0]} + 14'd7;
    assign w_head_is_wr = bus.p2p_cfg_req_head[c_IS_WR];
    assign w_unused_ok  = ^bus.p2p_cfg_req_head;

    assign w_req_ready  = (r_state == ST_WR) || (r_state == ST_RD_REQ);
    assign w_wr_hs      = (r_state == ST_WR) && bus.p2p_cfg_req_valid;

    assign bus.p2p_cfg_req_ready  = w_req_ready;
    assign bus.p2p_cfg_rrsp_valid = (r_state == ST_RD_RSP);
    assign bus.p2p_cfg_rrsp_last  = (r_state == ST_RD_RSP);
    // r_rdata is only non-zero while in RD_RSP, so no output gating needed
    assign bus.p2p_cfg_rrsp_data  = DATA_W'(r_rdata);

    // Per-register write strobe: word n of the request lands on reg S+n when
    // n is inside the word count and S+n does not run off the end of the bank
    always_comb begin
        for (int i = 0; i < REG_NUM; i++) begin
            w_we[i]    = 1'b0;
            w_wdata[i] = '0;
            for (int k = 0; k < c_WPB; k++) begin
                if (w_wr_hs
                    && ((int'(r_beat) * c_WPB + k) < int'(r_wcnt))
                    && ((int'(r_start) + int'(r_beat) * c_WPB + k) == i)) begin
                    w_we[i]    = 1'b1;
                    w_wdata[i] = bus.p2p_cfg_req_data[64*k +: 64];
                end
            end
        end
    end

    // Register file storage, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REG_NUM; i++) begin
                if (w_we[i]) begin
                    r_regs[i] <= w_wdata[i];
                end
            end
        end
    end

    // Request sequencing FSM with latched head fields and read response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_start <= '0;
            r_wcnt  <= '0;
            r_beat  <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.p2p_cfg_req_valid) begin
                        r_start <= w_head_start;
                        r_wcnt  <= w_len_rnd[13:3];
                        r_beat  <= '0;
                        r_state <= w_head_is_wr ? ST_WR : ST_RD_REQ;
                    end
                end
                ST_WR: begin
                    if (bus.p2p_cfg_req_valid) begin
                        // Saturate so a very long trailing stream never wraps
                        // back onto low word numbers
                        if (r_beat != 11'h7FF) begin
                            r_beat <= r_beat + 11'd1;
                        end
                        if (bus.p2p_cfg_req_last) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_RD_REQ: begin
                    if (bus.p2p_cfg_req_valid && bus.p2p_cfg_req_last) begin
                        // r_start spans exactly the bank, so it is always in range
                        r_rdata <= r_regs[r_start];
                        r_state <= ST_RD_RSP;
                    end
                end
                ST_RD_RSP: begin
                    if (bus.p2p_cfg_rrsp_ready) begin
                        r_rdata <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Flatten the register file onto the cfg_regs bus
    generate
        for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_cfg_out
            assign cfg_regs[64*gi +: 64] = r_regs[gi];
        end
    endgenerate

endmodule
`default_nettype wire
